// File: rtl/mpc_seq_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   - state_t      : FSM encoding (IDLE/RUN/FIX/DONE)
//   - DEF_DW       : default operand width, overridable with `DATA_WIDTH
//   - RADIX_LEGAL  : bit mask of legal RADIX_BITS values (bit r set => r legal)
//   - radixLegal() : helper for parameter checks in wrappers/benches
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mpc_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_DW = `DATA_WIDTH;

    // Radix 1, 2 and 4 only: wider chunks would need a deeper adder tree.
    localparam logic [4:0] RADIX_LEGAL = 5'b10110;

    function automatic bit radixLegal(input int dw, input int radix);
        return (radix >= 1) && (radix <= 4) && RADIX_LEGAL[radix] &&
               (dw >= 4) && ((dw % radix) == 0);
    endfunction

endpackage

// File: rtl/mpc_seq_mul_if.sv
// Operand/result handshake bundle for mpc_seq_mul.
//   slave  : the multiplier side (takes operands, drives result/status)
//   master : the EX-stage side (drives operands, flush, result ready)
// Signals: iValid/oReady (operand handshake), iSigned, iA, iB, iFlush,
//          oValid/iReady (result handshake), oProd (2*DW), oBusy.
interface mpc_seq_mul_if #(
    parameter int DW = mpc_mul_pkg::DEF_DW
);
    logic            iValid;
    logic            oReady;
    logic            iSigned;
    logic [DW-1:0]   iA;
    logic [DW-1:0]   iB;
    logic            iFlush;
    logic            oValid;
    logic            iReady;
    logic [2*DW-1:0] oProd;
    logic            oBusy;

    modport slave (
        input  iValid, iSigned, iA, iB, iFlush, iReady,
        output oReady, oValid, oProd, oBusy
    );

    modport master (
        output iValid, iSigned, iA, iB, iFlush, iReady,
        input  oReady, oValid, oProd, oBusy
    );
endinterface

// File: rtl/mpc_seq_mul_chunk.sv
// Combinational partial-product generator: iA * iChunk, where iChunk is a
// RADIX_BITS-wide slice of the multiplier. Built as RADIX_BITS AND-rows,
// each shifted by its bit position, summed into DW+RADIX_BITS bits (which
// cannot overflow since iChunk < 2^RADIX_BITS).
//   iA     in  DW          multiplicand magnitude
//   iChunk in  RADIX_BITS  multiplier slice
//   oPart  out DW+RADIX_BITS partial product
module mpc_mul_chunk
    import mpc_mul_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int RADIX_BITS = 2
) (
    input  logic [DW-1:0]            iA,
    input  logic [RADIX_BITS-1:0]    iChunk,
    output logic [DW+RADIX_BITS-1:0] oPart
);
    always_comb begin
        oPart = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            oPart = oPart + ({{RADIX_BITS{1'b0}}, iA & {DW{iChunk[i]}}} << i);
        end
    end
endmodule

// File: rtl/mpc_seq_mul.sv
// Iterative shift-add multiplier (MULT/MULTU engine). Operands are reduced
// to magnitudes at accept, RADIX_BITS multiplier bits are retired per RUN
// cycle into a 2*DW accumulator, and the sign is reapplied in FIX.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : iValid/oReady operand handshake, iSigned/iA/iB operands,
//                 iFlush abort, oValid/iReady result handshake, oProd, oBusy
module mpc_seq_mul
    import mpc_mul_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int RADIX_BITS = 2
) (
    input logic          clk,
    input logic          resetn,
    mpc_seq_mul_if.slave bus
);
    localparam int N  = DW / RADIX_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t                   state, nextState;
    logic [CW-1:0]            cnt;
    logic [DW-1:0]            magA, magB;
    logic                     sign;
    logic [2*DW-1:0]          acc, prod;
    logic [DW+RADIX_BITS-1:0] part;
    logic [2*DW-1:0]          partWide;
    logic                     accept, lastRun;

    // Flush wins over accept.
    assign accept   = bus.iValid & (state == IDLE) & ~bus.iFlush;
    assign lastRun  = (cnt == CW'(N - 1));
    assign partWide = {{(DW-RADIX_BITS){1'b0}}, part};

    mpc_mul_chunk #(.DW(DW), .RADIX_BITS(RADIX_BITS)) uChunk (
        .iA    (magA),
        .iChunk(magB[RADIX_BITS-1:0]),
        .oPart (part)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (bus.iFlush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.iValid) nextState = RUN;
                RUN:     if (lastRun)    nextState = FIX;
                FIX:                     nextState = DONE;
                DONE:    if (bus.iReady) nextState = IDLE;
                default:                 nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            magA <= '0;
            magB <= '0;
            sign <= 1'b0;
            acc  <= '0;
            prod <= '0;
        end else if (bus.iFlush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign <= bus.iSigned & (bus.iA[DW-1] ^ bus.iB[DW-1]);
                    // -(-2^(DW-1)) wraps to 2^(DW-1), the correct unsigned magnitude.
                    magA <= (bus.iSigned & bus.iA[DW-1]) ? -bus.iA : bus.iA;
                    magB <= (bus.iSigned & bus.iB[DW-1]) ? -bus.iB : bus.iB;
                    acc  <= '0;
                    cnt  <= '0;
                end
                RUN: begin
                    acc  <= acc + (partWide << (cnt * RADIX_BITS));
                    magB <= magB >> RADIX_BITS;
                    cnt  <= lastRun ? '0 : cnt + 1'b1;
                end
                FIX:     prod <= sign ? -acc : acc;
                default: ;
            endcase
        end
    end

    assign bus.oReady = (state == IDLE);
    assign bus.oValid = (state == DONE);
    assign bus.oBusy  = (state != IDLE);
    assign bus.oProd  = prod;
endmodule
